// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port among NREQ cache requesters.
// One transaction at a time; each grant is followed by an ACCESS phase that
// ends on ramready or on the watchdog, and always returns through IDLE.
module ram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*32-1:0]       req_addr,
    input  logic [NREQ*32-1:0]       req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [31:0]              req_load,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [31:0]              ramaddr,
    output logic [31:0]              ramstore,
    input  logic [31:0]              ramload,
    input  logic                     ramready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            ren_q, ren_d;
    logic            wen_q, wen_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     store_q, store_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] pend;
    logic            found;
    logic [IW-1:0]   sel;
    logic [IW:0]     rot_idx;
    logic [IW:0]     next_ptr;
    logic            completing;

    assign pend       = req_ren | req_wen;
    assign completing = (state_q == ACCESS) && ramready;

    // Rotating priority search: first pending requester at or after rr_ptr.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        rot_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (rot_idx >= (IW+1)'(NREQ))
                rot_idx = rot_idx - (IW+1)'(NREQ);
            if (!found && pend[rot_idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = rot_idx[IW-1:0];
            end
        end
        next_ptr = {1'b0, sel} + (IW+1)'(1);
        if (next_ptr >= (IW+1)'(NREQ))
            next_ptr = next_ptr - (IW+1)'(NREQ);
    end

    // Next-state logic: grant in IDLE, finish or time out in ACCESS.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ACCESS;
                    grant_d  = sel;
                    rr_ptr_d = next_ptr[IW-1:0];
                    cnt_d    = '0;
                    // A write wins when a requester raises both enables.
                    wen_d    = req_wen[sel];
                    ren_d    = ~req_wen[sel];
                    addr_d   = req_addr[sel*32 +: 32];
                    store_d  = req_store[sel*32 +: 32];
                end
            end
            ACCESS: begin
                if (ramready) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end else if (cnt_q == TW'(TIMEOUT-1)) begin
                    state_d   = IDLE;
                    ren_d     = 1'b0;
                    wen_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered RAM-side outputs; reset drops any RAM operation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            timeout_q <= timeout_d;
        end
    end

    assign ramREN      = ren_q;
    assign ramWEN      = wen_q;
    assign ramaddr     = addr_q;
    assign ramstore    = store_q;
    assign grant_id    = grant_q;
    assign timeout_err = timeout_q;
    assign req_load    = completing ? ramload : 32'h0;

    // Each requester stalls while pending, except in its own completion cycle.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
            assign req_wait[gi] = pend[gi] & ~(completing && (grant_q == IW'(gi)));
        end
    endgenerate

endmodule
